// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, reads a fixed-latency synchronous ROM
// and hands each word to the decoder over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for run or a step edge
// REQ     | one-cycle imem read strobe
// WAIT    | counting down the ROM latency, capture on the last count
// HOLD    | instruction presented, waiting for decoder accept
// WAIT_PC | waiting for the decoder PC update (increment or jump)
// HALTED  | terminal until reset
module instruction_fetch #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              halt,
    output logic              imem_ren,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              pc_en,
    input  logic              pc_inc0_jum1,
    input  logic [15:0]       pc_ext,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_WAIT_PC,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                step_q, step_d;
    logic                halt_pend_q, halt_pend_d;
    logic                step_edge;
    logic                unused_pc_ext;

    assign unused_pc_ext = ^pc_ext;
    assign step_edge     = step & ~step_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        step_d      = step;
        halt_pend_d = halt_pend_q;

        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (run || step_edge) begin
                    state_d = S_REQ;
                    addr_d  = pc_q;
                end
            end
            S_REQ: begin
                cnt_d       = 2'(MEM_LAT);
                halt_pend_d = halt_pend_q | halt;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    // A halt seen at any point during the read drops the word.
                    if (halt_pend_q || halt) begin
                        state_d     = S_HALTED;
                        halt_pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else begin
                    halt_pend_d = halt_pend_q | halt;
                end
            end
            S_HOLD: begin
                if (halt) begin
                    valid_d = 1'b0;
                    state_d = S_HALTED;
                end else if (ins_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (pc_en) begin
                    pc_d    = pc_inc0_jum1 ? pc_ext[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            addr_q      <= ADDR_W'(RESET_PC);
            instr_q     <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= 2'd0;
            step_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_ren    = (state_q == S_REQ);
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign ins_valid   = valid_q;
    assign pc_addr     = pc_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance at read latency 1, one at 3,
// each fed by a small ROM model that drives data only in its valid cycle.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, step, halt, ins_ready, pc_en, pc_inc0_jum1;
    logic [15:0] pc_ext;

    logic        ren1, valid1, busy1;
    logic [7:0]  addr1, pc1;
    logic [15:0] rdata1, instr1;
    logic        ren3, valid3, busy3;
    logic [7:0]  addr3, pc3;
    logic [15:0] rdata3, instr3;

    logic        ovr;
    logic [15:0] junk;

    int vecs = 0;
    int errs = 0;
    int ren1_cnt = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .RESET_PC(0)) u_dut1 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt(halt),
        .imem_ren(ren1), .imem_addr(addr1), .imem_rdata(rdata1),
        .instruction(instr1), .ins_valid(valid1), .ins_ready(ins_ready),
        .pc_en(pc_en), .pc_inc0_jum1(pc_inc0_jum1), .pc_ext(pc_ext),
        .pc_addr(pc1), .busy(busy1)
    );

    instruction_fetch #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3), .RESET_PC(0)) u_dut3 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt(halt),
        .imem_ren(ren3), .imem_addr(addr3), .imem_rdata(rdata3),
        .instruction(instr3), .ins_valid(valid3), .ins_ready(ins_ready),
        .pc_en(pc_en), .pc_inc0_jum1(pc_inc0_jum1), .pc_ext(pc_ext),
        .pc_addr(pc3), .busy(busy3)
    );

    function automatic logic [15:0] rom(input logic [7:0] a);
        return 16'h1030 ^ {a, a};
    endfunction

    // ROM models: data is only meaningful in the cycle it is due, 16'hDEAD otherwise.
    logic        v1;
    logic [15:0] d1;
    logic [2:0]  v3;
    logic [15:0] d3a, d3b, d3c;

    initial begin
        v1 = 1'b0;
        v3 = 3'b000;
    end

    always @(posedge clk) begin
        v1  <= ren1;
        d1  <= rom(addr1);
        v3  <= {v3[1:0], ren3};
        d3a <= rom(addr3);
        d3b <= d3a;
        d3c <= d3b;
    end

    assign rdata1 = ovr ? junk : (v1 ? d1 : 16'hDEAD);
    assign rdata3 = v3[2] ? d3c : 16'hDEAD;

    always @(posedge clk) begin
        if (ren1 === 1'b1) ren1_cnt <= ren1_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (valid1 !== 1'b1 && n < 30);
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; ins_ready = 1'b0;
        pc_en = 1'b0; pc_inc0_jum1 = 1'b0; pc_ext = 16'h0000; ovr = 1'b0; junk = 16'h0000;
        cyc(2);
        vecs++; if (pc1 !== 8'h00) begin errs++; $display("FAIL reset_pc: got %h want 00", pc1); end
        vecs++; if (addr1 !== 8'h00) begin errs++; $display("FAIL reset_addr: got %h want 00", addr1); end
        vecs++; if (ren1 !== 1'b0) begin errs++; $display("FAIL reset_ren: got %b want 0", ren1); end
        vecs++; if (instr1 !== 16'h0000) begin errs++; $display("FAIL reset_instr: got %h want 0000", instr1); end
        vecs++; if (valid1 !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid1); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy1); end
    endtask

    task automatic test_free_run;
        int k;
        int first_ren;
        logic [7:0] ren_addr;
        int rc;
        first_ren = 0;
        ren_addr  = 8'hxx;
        rc = ren1_cnt;
        rst = 1'b0;
        run = 1'b1;
        for (k = 1; k < 20; k++) begin
            cyc(1);
            if (ren1 === 1'b1 && first_ren == 0) begin
                first_ren = k;
                ren_addr  = addr1;
            end
            if (valid1 === 1'b1) break;
        end
        vecs++; if (first_ren != 1) begin errs++; $display("FAIL fr_req_cycle: got %0d want 1", first_ren); end
        vecs++; if (ren_addr !== 8'h00) begin errs++; $display("FAIL fr_req_addr: got %h want 00", ren_addr); end
        vecs++; if (k != 3) begin errs++; $display("FAIL fr_latency: got %0d want 3", k); end
        vecs++; if (instr1 !== 16'h1030) begin errs++; $display("FAIL fr_instr: got %h want 1030", instr1); end
        vecs++; if (pc1 !== 8'h00) begin errs++; $display("FAIL fr_pc: got %h want 00", pc1); end
        vecs++; if (ren1_cnt != rc + 1) begin errs++; $display("FAIL fr_ren_pulses: got %0d want %0d", ren1_cnt - rc, 1); end
    endtask

    task automatic test_backpressure;
        int rc;
        for (int i = 0; i < 5; i++) begin
            ovr  = 1'b1;
            junk = 16'hA5A0 + 16'(i);
            cyc(1);
            vecs++; if (valid1 !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, valid1); end
            vecs++; if (instr1 !== 16'h1030) begin errs++; $display("FAIL bp_instr[%0d]: got %h want 1030", i, instr1); end
        end
        ovr = 1'b0;
        ins_ready = 1'b1; pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'h0099;
        cyc(1);
        ins_ready = 1'b0; pc_en = 1'b0;
        vecs++; if (valid1 !== 1'b0) begin errs++; $display("FAIL bp_accept_valid: got %b want 0", valid1); end
        vecs++; if (pc1 !== 8'h00) begin errs++; $display("FAIL bp_accept_pc_en_ignored: got %h want 00", pc1); end
        rc = ren1_cnt;
        cyc(2);
        vecs++; if (busy1 !== 1'b1) begin errs++; $display("FAIL bp_waitpc_busy: got %b want 1", busy1); end
        vecs++; if (ren1_cnt != rc) begin errs++; $display("FAIL bp_waitpc_no_fetch: got %0d want 0", ren1_cnt - rc); end
    endtask

    task automatic test_jump;
        int n;
        pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'hFF37;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc1 !== 8'h37) begin errs++; $display("FAIL jmp_pc: got %h want 37", pc1); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL jmp_idle_busy: got %b want 0", busy1); end
        cyc(1);
        vecs++; if (ren1 !== 1'b1 || addr1 !== 8'h37) begin errs++; $display("FAIL jmp_req: got ren %b addr %h want ren 1 addr 37", ren1, addr1); end
        wait_valid1(n);
        vecs++; if (n != 2) begin errs++; $display("FAIL jmp_latency: got %0d want 2", n); end
        vecs++; if (instr1 !== 16'h2707) begin errs++; $display("FAIL jmp_instr: got %h want 2707", instr1); end
        pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'h0011;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc1 !== 8'h37) begin errs++; $display("FAIL jmp_hold_pc_en_ignored: got %h want 37", pc1); end
        ins_ready = 1'b1;
        cyc(1);
        ins_ready = 1'b0; pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'h00FF;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc1 !== 8'hFF) begin errs++; $display("FAIL jmp_pc_ff: got %h want ff", pc1); end
        cyc(1);
        vecs++; if (ren1 !== 1'b1 || addr1 !== 8'hFF) begin errs++; $display("FAIL jmp_req_ff: got ren %b addr %h want ren 1 addr ff", ren1, addr1); end
        wait_valid1(n);
        vecs++; if (instr1 !== 16'hEFCF) begin errs++; $display("FAIL jmp_instr_ff: got %h want efcf", instr1); end
        ins_ready = 1'b1;
        cyc(1);
        ins_ready = 1'b0; pc_en = 1'b1; pc_inc0_jum1 = 1'b0; pc_ext = 16'h1234;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc1 !== 8'h00) begin errs++; $display("FAIL inc_wrap_pc: got %h want 00", pc1); end
        cyc(1);
        vecs++; if (ren1 !== 1'b1 || addr1 !== 8'h00) begin errs++; $display("FAIL inc_wrap_req: got ren %b addr %h want ren 1 addr 00", ren1, addr1); end
    endtask

    task automatic test_single_step;
        int rc;
        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; ins_ready = 1'b1; pc_en = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        rc = ren1_cnt;
        step = 1'b1;
        cyc(10);
        vecs++; if (ren1_cnt != rc + 1) begin errs++; $display("FAIL ss_held_one_fetch: got %0d want 1", ren1_cnt - rc); end
        vecs++; if (busy1 !== 1'b1) begin errs++; $display("FAIL ss_waitpc_busy: got %b want 1", busy1); end
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
        vecs++; if (ren1_cnt != rc + 1) begin errs++; $display("FAIL ss_busy_edge_ignored: got %0d want 1", ren1_cnt - rc); end
        pc_en = 1'b1; pc_inc0_jum1 = 1'b0;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc1 !== 8'h01) begin errs++; $display("FAIL ss_inc_pc: got %h want 01", pc1); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL ss_idle_busy: got %b want 0", busy1); end
        cyc(4);
        vecs++; if (ren1_cnt != rc + 1) begin errs++; $display("FAIL ss_idle_no_fetch: got %0d want 1", ren1_cnt - rc); end
        step = 1'b1;
        cyc(1);
        vecs++; if (ren1 !== 1'b1 || addr1 !== 8'h01) begin errs++; $display("FAIL ss_second_req: got ren %b addr %h want ren 1 addr 01", ren1, addr1); end
        step = 1'b0;
        cyc(5);
        vecs++; if (ren1_cnt != rc + 2) begin errs++; $display("FAIL ss_second_fetch_count: got %0d want 2", ren1_cnt - rc); end
    endtask

    task automatic test_halt;
        int rc;
        int bad1;
        int bad3;
        bad1 = 0;
        bad3 = 0;
        rst = 1'b1; run = 1'b1; step = 1'b0; halt = 1'b0; ins_ready = 1'b0; pc_en = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        vecs++; if (ren1 !== 1'b1 || ren3 !== 1'b1) begin errs++; $display("FAIL halt_req: got ren1 %b ren3 %b want 1 1", ren1, ren3); end
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (valid1 !== 1'b0) bad1++;
            if (valid3 !== 1'b0) bad3++;
        end
        vecs++; if (bad1 != 0) begin errs++; $display("FAIL halt_valid1: got %0d cycles valid want 0", bad1); end
        vecs++; if (bad3 != 0) begin errs++; $display("FAIL halt_valid3: got %0d cycles valid want 0", bad3); end
        vecs++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errs++; $display("FAIL halt_busy: got busy1 %b busy3 %b want 0 0", busy1, busy3); end
        rc = ren1_cnt;
        step = 1'b1; pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'h0042;
        cyc(2);
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(3);
        step = 1'b0; pc_en = 1'b0;
        vecs++; if (ren1_cnt != rc) begin errs++; $display("FAIL halt_no_fetch: got %0d want 0", ren1_cnt - rc); end
        vecs++; if (pc1 !== 8'h00) begin errs++; $display("FAIL halt_pc_en_ignored: got %h want 00", pc1); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL halt_stays: got busy %b want 0", busy1); end
    endtask

    task automatic test_reset_mid_wait;
        int k;
        int first_ren;
        rst = 1'b1; run = 1'b1; step = 1'b0; halt = 1'b0; ins_ready = 1'b0; pc_en = 1'b0;
        cyc(1);
        rst = 1'b0;
        first_ren = 0;
        for (k = 1; k < 20; k++) begin
            cyc(1);
            if (ren3 === 1'b1 && first_ren == 0) first_ren = k;
            if (valid3 === 1'b1) break;
        end
        vecs++; if (first_ren != 1 || k != 5) begin errs++; $display("FAIL lat3_latency: got req %0d valid %0d want req 1 valid 5", first_ren, k); end
        vecs++; if (instr3 !== 16'h1030) begin errs++; $display("FAIL lat3_instr: got %h want 1030", instr3); end
        ins_ready = 1'b1;
        cyc(1);
        ins_ready = 1'b0; pc_en = 1'b1; pc_inc0_jum1 = 1'b1; pc_ext = 16'hAB55;
        cyc(1);
        pc_en = 1'b0;
        vecs++; if (pc3 !== 8'h55) begin errs++; $display("FAIL lat3_jump_pc: got %h want 55", pc3); end
        cyc(1);
        vecs++; if (ren3 !== 1'b1 || addr3 !== 8'h55) begin errs++; $display("FAIL lat3_req: got ren %b addr %h want ren 1 addr 55", ren3, addr3); end
        cyc(1);
        #2 rst = 1'b1;
        #1;
        vecs++; if (pc3 !== 8'h00 || addr3 !== 8'h00) begin errs++; $display("FAIL async_rst_pc_addr: got pc %h addr %h want 00 00", pc3, addr3); end
        vecs++; if (ren3 !== 1'b0 || valid3 !== 1'b0 || busy3 !== 1'b0) begin errs++; $display("FAIL async_rst_ctrl: got ren %b valid %b busy %b want 0 0 0", ren3, valid3, busy3); end
        vecs++; if (instr3 !== 16'h0000) begin errs++; $display("FAIL async_rst_instr: got %h want 0000", instr3); end
        @(negedge clk);
        rst = 1'b0;
        first_ren = 0;
        for (k = 1; k < 20; k++) begin
            cyc(1);
            if (ren3 === 1'b1 && first_ren == 0) begin
                first_ren = k;
                vecs++; if (addr3 !== 8'h00) begin errs++; $display("FAIL restart_addr: got %h want 00", addr3); end
            end
            if (valid3 === 1'b1) break;
        end
        vecs++; if (first_ren != 1 || k != 5) begin errs++; $display("FAIL restart_latency: got req %0d valid %0d want req 1 valid 5", first_ren, k); end
        vecs++; if (instr3 !== 16'h1030) begin errs++; $display("FAIL restart_instr: got %h want 1030", instr3); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_jump();
        test_single_step();
        test_halt();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
